// File: rtl/mem_loader.sv
// mem_loader: program loader for the memory flash port.
// Receives a little-endian byte stream (4-byte word count N, then N words),
// assembles 32-bit words and writes each one to consecutive word addresses
// starting at BASE_ADDR. The core is held in reset until the image has been
// written completely; an oversized count parks the loader in an error state.

module mem_loader #(
  parameter int WIDTH     = 32,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             flash_en,
  output logic [WIDTH-1:0] flash_addr,
  output logic [WIDTH-1:0] flash_data,
  output logic             core_rst,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {
    LEN,
    DATA,
    WRITE,
    GAP,
    DONE,
    ERR
  } state_t;

  localparam logic [WIDTH-1:0] BASE  = WIDTH'(BASE_ADDR);
  localparam logic [WIDTH-1:0] MAX_N = WIDTH'(MAX_WORDS);

  state_t           state;
  logic [1:0]       byte_cnt;
  logic [WIDTH-1:0] word_idx;
  logic [WIDTH-1:0] word_cnt;
  logic [WIDTH-9:0] shift_reg;

  logic             accept;
  logic             last_byte;
  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] next_word;
  logic [WIDTH-1:0] word_addr;
  logic             last_word;

  // Handshake and datapath helpers: the incoming byte lands in the top byte,
  // so after four shifts the first byte received sits in bits [7:0].
  always_comb begin
    in_ready   = !rst && ((state == LEN) || (state == DATA));
    accept     = in_valid && in_ready;
    last_byte  = (byte_cnt == 2'd3);
    next_count = {in_data, word_cnt[WIDTH-1:8]};
    next_word  = {in_data, shift_reg};
    word_addr  = BASE + {word_idx[WIDTH-3:0], 2'b00};
    last_word  = (word_idx == (word_cnt - WIDTH'(1)));
  end

  // Loader FSM with registered flash strobe, address, data and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LEN;
      byte_cnt   <= 2'd0;
      word_idx   <= '0;
      word_cnt   <= '0;
      shift_reg  <= '0;
      flash_en   <= 1'b0;
      flash_addr <= '0;
      flash_data <= '0;
      core_rst   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        LEN: begin
          if (accept) begin
            word_cnt <= next_count;
            byte_cnt <= byte_cnt + 2'd1;
            if (last_byte) begin
              if (next_count == '0) begin
                state    <= DONE;
                done     <= 1'b1;
                core_rst <= 1'b0;
              end else if (next_count > MAX_N) begin
                state <= ERR;
                error <= 1'b1;
              end else begin
                state <= DATA;
              end
            end
          end
        end

        DATA: begin
          if (accept) begin
            shift_reg <= next_word[WIDTH-1:8];
            byte_cnt  <= byte_cnt + 2'd1;
            if (last_byte) begin
              flash_en   <= 1'b1;
              flash_addr <= word_addr;
              flash_data <= next_word;
              state      <= WRITE;
            end
          end
        end

        WRITE: begin
          flash_en <= 1'b0;
          state    <= GAP;
        end

        GAP: begin
          if (last_word) begin
            state    <= DONE;
            done     <= 1'b1;
            core_rst <= 1'b0;
          end else begin
            word_idx <= word_idx + WIDTH'(1);
            state    <= DATA;
          end
        end

        DONE: begin
          state <= DONE;
        end

        ERR: begin
          state <= ERR;
        end

        default: begin
          state <= LEN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed and randomized load images driven into two loaders
// (base 0 and base 0x100) sharing one byte stream; flash writes are compared
// against the list of words that built the image.

module tb_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;

  logic        in_ready0, flash_en0, core_rst0, done0, error0;
  logic [31:0] flash_addr0, flash_data0;
  logic        in_ready1, flash_en1, core_rst1, done1, error1;
  logic [31:0] flash_addr1, flash_data1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [7:0]  tx_bytes[$];
  logic [7:0]  full_bytes[$];
  logic [31:0] exp_words[$];
  int          fire_cyc[$];

  logic [31:0] wr_addr0[$];
  logic [31:0] wr_data0[$];
  int          wr_cyc0[$];
  logic [31:0] wr_addr1[$];
  logic [31:0] wr_data1[$];
  int          done_cyc;

  mem_loader #(.WIDTH(32), .BASE_ADDR(0), .MAX_WORDS(256)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .flash_en(flash_en0), .flash_addr(flash_addr0),
    .flash_data(flash_data0), .core_rst(core_rst0), .done(done0), .error(error0)
  );

  mem_loader #(.WIDTH(32), .BASE_ADDR(32'h100), .MAX_WORDS(256)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .flash_en(flash_en1), .flash_addr(flash_addr1),
    .flash_data(flash_data1), .core_rst(core_rst1), .done(done1), .error(error1)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter used to timestamp handshakes and strobes
  always @(posedge clk) cyc <= cyc + 1;

  // Record every flash write and the first cycle done is seen
  always @(negedge clk) begin
    if (rst) begin
      wr_addr0.delete(); wr_data0.delete(); wr_cyc0.delete();
      wr_addr1.delete(); wr_data1.delete();
      done_cyc = -1;
    end else begin
      if (flash_en0) begin
        wr_addr0.push_back(flash_addr0);
        wr_data0.push_back(flash_data0);
        wr_cyc0.push_back(cyc);
      end
      if (flash_en1) begin
        wr_addr1.push_back(flash_addr1);
        wr_data1.push_back(flash_data1);
      end
      if (done0 && done_cyc < 0) done_cyc = cyc;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void buildImage(input logic [31:0] count);
    tx_bytes.delete();
    for (int b = 0; b < 4; b++) tx_bytes.push_back(8'((count >> (8 * b)) & 32'hff));
    foreach (exp_words[i])
      for (int b = 0; b < 4; b++) tx_bytes.push_back(8'((exp_words[i] >> (8 * b)) & 32'hff));
  endfunction

  task automatic resetDuts();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    fire_cyc.delete();
  endtask

  // Sends tx_bytes; mode 0 = valid held high, 1 = toggling, 2 = random gaps
  task automatic applyStimulus(input int mode, input int budget);
    int  idx = 0;
    int  spent = 0;
    bit  tog = 1'b1;
    bit  fire;
    while (idx < tx_bytes.size() && spent < budget) begin
      case (mode)
        0: in_valid = 1'b1;
        1: begin in_valid = tog; tog = !tog; end
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = in_valid ? tx_bytes[idx] : 8'($urandom);
      @(negedge clk);
      fire = in_valid && in_ready0;
      if (fire) fire_cyc.push_back(cyc);
      @(posedge clk); #1;
      if (fire) idx++;
      spent++;
    end
    in_valid = 1'b0;
    in_data = 8'h00;
    checkOutput("stream_consumed", idx, tx_bytes.size());
  endtask

  task automatic verifyLoad(input string tag);
    int n = exp_words.size();
    int exp_done;
    int k;
    repeat (12) @(posedge clk);
    #1;
    checkOutput({tag, "_nwr0"}, wr_addr0.size(), n);
    checkOutput({tag, "_nwr1"}, wr_addr1.size(), n);
    for (int i = 0; i < n && i < wr_addr0.size(); i++) begin
      k = 4 * i + 7;
      checkOutput({tag, "_addr0"}, wr_addr0[i], 32'(4 * i));
      checkOutput({tag, "_data0"}, wr_data0[i], exp_words[i]);
      checkOutput({tag, "_wcyc"}, wr_cyc0[i], (k < fire_cyc.size()) ? fire_cyc[k] + 1 : -2);
    end
    for (int i = 0; i < n && i < wr_addr1.size(); i++) begin
      checkOutput({tag, "_addr1"}, wr_addr1[i], 32'h100 + 32'(4 * i));
      checkOutput({tag, "_data1"}, wr_data1[i], exp_words[i]);
    end
    k = 4 * n + 3;
    if (k < fire_cyc.size()) exp_done = (n == 0) ? fire_cyc[k] + 1 : fire_cyc[k] + 3;
    else exp_done = -2;
    checkOutput({tag, "_done_cyc"}, done_cyc, exp_done);
    checkOutput({tag, "_done"}, {done1, done0}, 2'b11);
    checkOutput({tag, "_core_rst"}, {core_rst1, core_rst0}, 2'b00);
    checkOutput({tag, "_error"}, {error1, error0}, 2'b00);
    checkOutput({tag, "_in_ready"}, in_ready0, 1'b0);
  endtask

  initial begin
    int fires;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", {in_ready1, in_ready0}, 2'b00);
    checkOutput("rst_flash_en", flash_en0, 1'b0);
    checkOutput("rst_flash_addr", flash_addr0, 32'h0);
    checkOutput("rst_flash_data", flash_data0, 32'h0);
    checkOutput("rst_flags", {core_rst0, done0, error0}, 3'b100);
    rst = 1'b0;
    #1;
    checkOutput("len_in_ready", in_ready0, 1'b1);

    // Three words, valid held high
    resetDuts();
    exp_words = '{32'd12345, 32'd678910, 32'hDEADBEEF};
    buildImage(32'd3);
    applyStimulus(0, 200);
    verifyLoad("n3_solid");

    // Same image, valid toggling
    resetDuts();
    buildImage(32'd3);
    applyStimulus(1, 400);
    verifyLoad("n3_toggle");

    // Empty image
    resetDuts();
    exp_words.delete();
    buildImage(32'd0);
    applyStimulus(0, 50);
    verifyLoad("n0");

    // Oversized count: error, nothing written, further bytes refused
    resetDuts();
    exp_words.delete();
    buildImage(32'd257);
    applyStimulus(0, 50);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("err_error", {error1, error0}, 2'b11);
    checkOutput("err_core_rst", {core_rst1, core_rst0}, 2'b11);
    checkOutput("err_done", done0, 1'b0);
    checkOutput("err_in_ready", in_ready0, 1'b0);
    fires = 0;
    in_valid = 1'b1;
    in_data = 8'h5A;
    repeat (8) begin
      @(negedge clk);
      if (in_valid && in_ready0) fires++;
    end
    in_valid = 1'b0;
    checkOutput("err_no_consume", fires, 0);
    checkOutput("err_no_writes", wr_addr0.size() + wr_addr1.size(), 0);

    // Byte ordering with both bases
    resetDuts();
    exp_words = '{32'h11223344, 32'hAABBCCDD};
    buildImage(32'd2);
    checkOutput("order_byte4", tx_bytes[4], 8'h44);
    applyStimulus(2, 300);
    verifyLoad("order");

    // Reset after two bytes of the first word, then reload
    resetDuts();
    exp_words = '{$urandom, $urandom, $urandom};
    buildImage(32'd3);
    full_bytes = tx_bytes;
    tx_bytes = full_bytes[0:5];
    applyStimulus(0, 50);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = full_bytes[6];
    #1;
    checkOutput("midrst_in_ready", {in_ready1, in_ready0}, 2'b00);
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_flash_en", {flash_en1, flash_en0}, 2'b00);
    checkOutput("midrst_addr", flash_addr1, 32'h0);
    checkOutput("midrst_data", flash_data0, 32'h0);
    checkOutput("midrst_flags", {core_rst0, done0, error0}, 3'b100);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    fire_cyc.delete();
    tx_bytes = full_bytes;
    applyStimulus(0, 200);
    verifyLoad("reload");

    // Randomized images with random valid gaps
    for (int t = 0; t < 4; t++) begin
      resetDuts();
      exp_words.delete();
      for (int w = 0; w < int'($urandom_range(1, 6)); w++) exp_words.push_back($urandom);
      buildImage(32'(exp_words.size()));
      applyStimulus(2, 800);
      verifyLoad("random");
    end

    // Largest accepted image
    resetDuts();
    exp_words.delete();
    for (int w = 0; w < 256; w++) exp_words.push_back($urandom);
    buildImage(32'd256);
    applyStimulus(0, 4000);
    verifyLoad("max_words");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
